// File: rtl/miner_job_loader.sv
// miner_job_loader: assembles a 21-word host job into a shadow register and commits it atomically to the mining core.
// Latency: the last word accepted in cycle T updates block/nonce_start/job_id at edge T+1; miner_reset is held RESET_CYCLES cycles.
// Backpressure: in_ready drops for 1+RESET_CYCLES cycles per commit; optional gap timeout under macro LOADER_TIMEOUT_EN.
module miner_job_loader #(
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  output logic [639:0] block,
  output logic [31:0]  nonce_start,
  output logic         miner_reset,
  output logic         running,
  output logic [7:0]   job_id,
  output logic         frame_err
);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_COMMIT = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  localparam logic [4:0] LAST_WORD = 5'd20;
  localparam logic [7:0] HOLD_INIT = 8'(RESET_CYCLES - 1);

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic [4:0]   word_cnt;
  logic [7:0]   hold_cnt;
  logic [639:0] shadow;
  logic         accept;
  logic         timeout;

  assign accept = in_valid & in_ready;

`ifdef LOADER_TIMEOUT_EN
  logic [15:0] gap_cnt;

  // An accepted word in the same cycle always beats the timeout.
  assign timeout = (state == ST_LOAD) && (word_cnt != 5'd0) && !accept &&
                   (gap_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Idle-gap counter: only runs while a partial frame is waiting.
  always_ff @(posedge clk) begin
    if (reset || accept || timeout || (state != ST_LOAD) || (word_cnt == 5'd0)) begin
      gap_cnt <= 16'd0;
    end else begin
      gap_cnt <= gap_cnt + 16'd1;
    end
  end
`else
  // Without the timeout a partial frame waits forever; the parameter only ties this off.
  assign timeout = (TIMEOUT_CYCLES < 1);
`endif

  // Next-state decode for the LOAD -> COMMIT -> HOLD -> LOAD cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:   if (accept && (word_cnt == LAST_WORD) && in_last) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_HOLD;
      ST_HOLD:   if (hold_cnt == 8'd0) state_nxt = ST_LOAD;
      default:   state_nxt = ST_LOAD;
    endcase
  end

  // Control, commit and core-reset sequencing; every output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_LOAD;
      in_ready    <= 1'b0;
      word_cnt    <= 5'd0;
      hold_cnt    <= 8'd0;
      frame_err   <= 1'b0;
      block       <= '0;
      nonce_start <= 32'd0;
      miner_reset <= 1'b1;
      running     <= 1'b0;
      job_id      <= 8'd0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == ST_LOAD);
      frame_err <= 1'b0;

      if (accept) begin
        if (word_cnt == LAST_WORD) begin
          word_cnt <= 5'd0;
          if (in_last) begin
            // Atomic commit: the nonce word goes straight to the core alongside the shadow.
            block       <= shadow;
            nonce_start <= in_data;
            job_id      <= job_id + 8'd1;
            miner_reset <= 1'b1;
            running     <= 1'b0;
          end else begin
            frame_err <= 1'b1;
          end
        end else if (in_last) begin
          word_cnt  <= 5'd0;
          frame_err <= 1'b1;
        end else begin
          word_cnt <= word_cnt + 5'd1;
        end
      end else if (timeout) begin
        word_cnt  <= 5'd0;
        frame_err <= 1'b1;
      end

      // Release the core one cycle before LOAD so miner_reset spans exactly RESET_CYCLES
      // while in_ready stays low for the extra COMMIT cycle.
      if (state == ST_COMMIT) begin
        hold_cnt <= HOLD_INIT;
      end else if ((state == ST_HOLD) && (hold_cnt != 8'd0)) begin
        hold_cnt <= hold_cnt - 8'd1;
        if (hold_cnt == 8'd1) begin
          miner_reset <= 1'b0;
          running     <= 1'b1;
        end
      end
    end
  end

  // Shadow datapath: header words land MSB-first; stale contents are simply overwritten.
  always_ff @(posedge clk) begin
    if (accept && !in_last && (word_cnt < LAST_WORD)) begin
      for (int k = 0; k < 20; k++) begin
        if (word_cnt == 5'(k)) shadow[639-32*k -: 32] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_miner_job_loader.sv
// Testbench for miner_job_loader: directed sequences, a frame table and random traffic against a frame-level model.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: every wait on in_ready is bounded and counted as a failure if it expires.
module tb_miner_job_loader;

  localparam int RC = 4;
`ifdef LOADER_TIMEOUT_EN
  localparam int TO    = 16;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 1024;
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = 32'd0;
  logic         in_last = 1'b0;
  logic [639:0] block;
  logic [31:0]  nonce_start;
  logic         miner_reset;
  logic         running;
  logic [7:0]   job_id;
  logic         frame_err;

  miner_job_loader #(.RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .block(block), .nonce_start(nonce_start),
    .miner_reset(miner_reset), .running(running), .job_id(job_id), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;

  // Frame-level reference model: words collected in a queue, output timing from edges since commit.
  logic [31:0]  m_words[$];
  logic [639:0] m_block;
  logic [31:0]  m_nonce;
  logic [7:0]   m_job;
  logic         m_running, m_mreset, m_ready, m_err;
  int           m_since, m_gap;

  task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit acc;
    if (reset) begin
      m_words.delete();
      m_block = '0; m_nonce = '0; m_job = '0;
      m_running = 1'b0; m_mreset = 1'b1; m_ready = 1'b0; m_err = 1'b0;
      m_since = 0; m_gap = 0;
      return;
    end
    acc = in_valid && m_ready;
    m_err = 1'b0;
    if (m_since > 0 && m_since < 1000) m_since++;
    if (acc) begin
      m_gap = 0;
      if (m_words.size() == 20) begin
        if (in_last) begin
          for (int k = 0; k < 20; k++) m_block[639-32*k -: 32] = m_words[k];
          m_nonce = in_data;
          m_job = m_job + 8'd1;
          m_since = 1;
        end else begin
          m_err = 1'b1;
        end
        m_words.delete();
      end else if (in_last) begin
        m_err = 1'b1;
        m_words.delete();
      end else begin
        m_words.push_back(in_data);
      end
    end else if (TO_EN && m_words.size() > 0) begin
      if (m_gap == TO - 1) begin
        m_err = 1'b1;
        m_words.delete();
        m_gap = 0;
      end else begin
        m_gap++;
      end
    end else begin
      m_gap = 0;
    end
    if (m_since > 0) begin
      m_mreset  = (m_since <= RC);
      m_running = (m_since > RC);
      m_ready   = (m_since > RC + 1);
    end else begin
      m_ready = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (frame_err === 1'b1) err_seen++;
    check("in_ready", in_ready, m_ready);
    check("frame_err", frame_err, m_err);
    check("miner_reset", miner_reset, m_mreset);
    check("running", running, m_running);
    check("job_id", job_id, m_job);
    check("nonce_start", nonce_start, m_nonce);
    check("block", block, m_block);
  endtask

  task automatic send_word(input logic [31:0] d, input bit l);
    bit r;
    bit done;
    done = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int w = 0; w < 100 && !done; w++) begin
      r = in_ready;
      tick();
      if (r) done = 1'b1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("send_word_accepted", done, 1'b1);
  endtask

  task automatic wait_ready();
    for (int w = 0; w < 100 && in_ready !== 1'b1; w++) tick();
    check("wait_ready", in_ready, 1'b1);
  endtask

  task automatic send_frame(input logic [31:0] base, input logic [31:0] nonce,
                            input int n, input int last_at, input int gap);
    for (int k = 0; k < n; k++) begin
      if (gap > 0 && k > 0 && (k % gap) == 0) tick();
      send_word((k == 20) ? nonce : base + 32'(k), k == last_at);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  typedef struct {
    int          n;
    int          last_at;
    int          gap;
    logic [31:0] nonce;
    int          exp_errs;
    logic [7:0]  exp_job;
    logic [31:0] exp_nonce;
  } fvec_t;

  fvec_t vecs[5];

  initial begin
    int cnt;
    int e0;
    vecs[0] = '{n: 21, last_at: 20, gap: 0, nonce: 32'hA0, exp_errs: 0, exp_job: 8'd1, exp_nonce: 32'hA0};
    vecs[1] = '{n: 1,  last_at: 0,  gap: 0, nonce: 32'hB0, exp_errs: 1, exp_job: 8'd1, exp_nonce: 32'hA0};
    vecs[2] = '{n: 20, last_at: 19, gap: 0, nonce: 32'hC0, exp_errs: 1, exp_job: 8'd1, exp_nonce: 32'hA0};
    vecs[3] = '{n: 21, last_at: -1, gap: 0, nonce: 32'hD0, exp_errs: 1, exp_job: 8'd1, exp_nonce: 32'hA0};
    vecs[4] = '{n: 21, last_at: 20, gap: 2, nonce: 32'hE0, exp_errs: 0, exp_job: 8'd2, exp_nonce: 32'hE0};

    // Reset behaviour and idle
    reset = 1'b1;
    tick(); tick();
    check("ready_in_reset", in_ready, 1'b0);
    reset = 1'b0;
    tick();
    check("ready_after_reset", in_ready, 1'b1);
    for (int i = 0; i < 50; i++) tick();
    check("idle_miner_reset", miner_reset, 1'b1);
    check("idle_running", running, 1'b0);
    check("idle_block", block, 640'd0);
    check("idle_in_ready", in_ready, 1'b1);
    check("idle_job_id", job_id, 8'd0);

    // First job: counting words, then exact reset window
    for (int k = 0; k < 20; k++) send_word(32'(k), 1'b0);
    check("pre_commit_block", block, 640'd0);
    send_word(32'h1000_0000, 1'b1);
    check("t2_block_top", block[639:608], 32'h0);
    check("t2_block_target", block[31:0], 32'h13);
    check("t2_block_w1", block[607:576], 32'h1);
    check("t2_nonce", nonce_start, 32'h1000_0000);
    check("t2_job_id", job_id, 8'd1);
    cnt = 0;
    while (miner_reset === 1'b1 && cnt < 50) begin cnt++; tick(); end
    check("t2_miner_reset_cycles", cnt, RC);
    check("t2_running", running, 1'b1);

    // Second job with valid gaps while the first one mines
    for (int k = 0; k < 20; k++) begin
      if ((k % 3) == 2) tick();
      send_word(32'h2000_0000 + 32'(k), 1'b0);
    end
    check("t3_block_unchanged", block[31:0], 32'h13);
    check("t3_job_unchanged", job_id, 8'd1);
    send_word(32'h2222_0000, 1'b1);
    check("t3_job_id", job_id, 8'd2);
    check("t3_block_target", block[31:0], 32'h2000_0013);
    cnt = 0;
    while (in_ready !== 1'b1 && cnt < 50) begin cnt++; tick(); end
    check("t3_ready_low_cycles", cnt, RC + 1);

    // Early in_last on word 7
    e0 = err_seen;
    for (int k = 0; k < 7; k++) send_word(32'h3000_0000 + 32'(k), 1'b0);
    send_word(32'h3000_0007, 1'b1);
    check("t4_frame_err_pulse", frame_err, 1'b1);
    check("t4_job_unchanged", job_id, 8'd2);
    check("t4_running", running, 1'b1);
    check("t4_block_unchanged", block[31:0], 32'h2000_0013);
    tick();
    check("t4_frame_err_low", frame_err, 1'b0);
    check("t4_err_count", err_seen - e0, 1);
    send_frame(32'h4000_0000, 32'h4444_0000, 21, 20, 0);
    check("t4_recover_job", job_id, 8'd3);
    wait_ready();

    // Reset in the middle of the second frame
    do_reset();
    send_frame(32'h5000_0000, 32'h5555_0000, 21, 20, 0);
    wait_ready();
    e0 = err_seen;
    for (int k = 0; k < 10; k++) send_word(32'h6000_0000 + 32'(k), 1'b0);
    in_valid = 1'b1; in_data = 32'h6000_000A; reset = 1'b1;
    tick(); tick();
    in_valid = 1'b0; reset = 1'b0;
    tick();
    send_frame(32'h7000_0000, 32'h7777_0000, 21, 20, 0);
    check("t5_job_id", job_id, 8'd1);
    check("t5_nonce", nonce_start, 32'h7777_0000);
    check("t5_no_frame_err", err_seen - e0, 0);
    wait_ready();

    // Frame table
    do_reset();
    for (int i = 0; i < 5; i++) begin
      e0 = err_seen;
      send_frame(32'h100 * 32'(i + 1), vecs[i].nonce, vecs[i].n, vecs[i].last_at, vecs[i].gap);
      wait_ready();
      check($sformatf("vec%0d_errs", i), err_seen - e0, vecs[i].exp_errs);
      check($sformatf("vec%0d_job", i), job_id, vecs[i].exp_job);
      check($sformatf("vec%0d_nonce", i), nonce_start, vecs[i].exp_nonce);
    end

`ifdef LOADER_TIMEOUT_EN
    // Gap timeout, and a word arriving exactly on the last idle cycle
    e0 = err_seen;
    for (int k = 0; k < 5; k++) send_word(32'h8000_0000 + 32'(k), 1'b0);
    for (int i = 0; i < TO - 1; i++) tick();
    check("to_no_early_err", err_seen - e0, 0);
    tick();
    check("to_frame_err", frame_err, 1'b1);
    e0 = err_seen;
    for (int k = 0; k < 5; k++) send_word(32'h9000_0000 + 32'(k), 1'b0);
    for (int i = 0; i < TO - 1; i++) tick();
    send_word(32'h9000_0005, 1'b0);
    check("to_word_wins", frame_err, 1'b0);
    for (int k = 6; k < 20; k++) send_word(32'h9000_0000 + 32'(k), 1'b0);
    send_word(32'h9999_0000, 1'b1);
    check("to_commit_job", job_id, 8'd3);
    check("to_no_err", err_seen - e0, 0);
    wait_ready();
`else
    // A partial frame survives a long idle gap
    e0 = err_seen;
    for (int k = 0; k < 5; k++) send_word(32'h8000_0000 + 32'(k), 1'b0);
    for (int i = 0; i < 1100; i++) tick();
    for (int k = 5; k < 20; k++) send_word(32'h8000_0000 + 32'(k), 1'b0);
    send_word(32'h8888_0000, 1'b1);
    check("gap_commit_job", job_id, 8'd3);
    check("gap_block_w0", block[639:608], 32'h8000_0000);
    check("gap_no_err", err_seen - e0, 0);
    wait_ready();
`endif

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 499) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = $urandom;
      if (m_words.size() == 20) in_last = ($urandom_range(0, 9) != 0);
      else                      in_last = ($urandom_range(0, 39) == 0);
      tick();
    end
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
